rv_mc_ctrl: RTL and testbench

RV_MC_CTRL -- requirements
Module: rv_mc_ctrl

---
 rtl/rv_pkg.sv | 90 +++++++++
 rtl/rv_mc_ctrl_if.sv | 38 +++
 rtl/rv_decode.sv | 109 ++++++++++
 rtl/rv_mc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// No logic of its own; types and constants only.
// Imported by the decoder, the controller and its interface users.
package rv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00001,
    ALU_SUB  = 5'b00011,
    ALU_AND  = 5'b01010,
    ALU_OR   = 5'b01100,
    ALU_XOR  = 5'b01101,
    ALU_SLL  = 5'b01110,
    ALU_SRL  = 5'b01111,
    ALU_SRA  = 5'b10000,
    ALU_SLT  = 5'b10001,
    ALU_SLTU = 5'b10010
  } alu_op_e;

  typedef enum logic [2:0] {
    LS_LW = 3'b000, LS_SB = 3'b001, LS_SH = 3'b010, LS_SW = 3'b011,
    LS_LB = 3'b100, LS_LH = 3'b101, LS_LBU = 3'b110, LS_LHU = 3'b111
  } ls_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100
  } imm_sel_e;

  typedef enum logic [1:0] {
    TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_FETCH_TO = 2'b10, TC_DATA_TO = 2'b11
  } trap_cause_e;

  // Instruction class decides the path taken out of EXEC.
  typedef enum logic [2:0] {
    CL_ALU, CL_JUMP, CL_LOAD, CL_STORE, CL_BRANCH, CL_FENCE
  } iclass_e;

  typedef enum logic [5:0] {
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_EXEC   = 6'b000100,
    S_MEM    = 6'b001000,
    S_WB     = 6'b010000,
    S_TRAP   = 6'b100000
  } state_e;

  localparam logic [1:0] ASEL_ZERO = 2'b00;
  localparam logic [1:0] ASEL_RS1  = 2'b01;
  localparam logic [1:0] ASEL_PC   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    alu_op_e  alu_op;
    logic [1:0] a_sel;
    logic     b_sel;
    imm_sel_e imm_sel;
    ls_op_e   ls_op;
    iclass_e  cls;
  } ctrl_t;

  // funct3 -> ALU op; alt selects SUB/SRA where funct7[5] is set.
  function automatic alu_op_e alu_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_mc_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and its datapath.
// Pure wiring, no latency.
// Handshakes are level req/ready pairs; the controller holds requests until ready.
interface rv_mc_ctrl_if #(parameter int ALUOP_W = 5);
  logic [31:0]        instr;
  logic               imem_ready;
  logic               alu_valid;
  logic               br_taken;
  logic               dmem_ready;
  logic               imem_req;
  logic               ir_we;
  logic               alu_start;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         a_sel;
  logic               b_sel;
  logic [2:0]         imm_sel;
  logic               dmem_req;
  logic               dmem_we;
  logic [2:0]         ls_op;
  logic               rf_we;
  logic [1:0]         wb_sel;
  logic               pc_we;
  logic               pc_sel;
  logic               trap;
  logic [1:0]         trap_cause;

  modport master (
    input  instr, imem_ready, alu_valid, br_taken, dmem_ready,
    output imem_req, ir_we, alu_start, alu_op, a_sel, b_sel, imm_sel,
           dmem_req, dmem_we, ls_op, rf_we, wb_sel, pc_we, pc_sel, trap, trap_cause
  );

  modport slave (
    output instr, imem_ready, alu_valid, br_taken, dmem_ready,
    input  imem_req, ir_we, alu_start, alu_op, a_sel, b_sel, imm_sel,
           dmem_req, dmem_we, ls_op, rf_we, wb_sel, pc_we, pc_sel, trap, trap_cause
  );
endinterface

// File: rtl/rv_decode.sv
// RV32I instruction decoder: instr -> control word plus illegal flag.
// Purely combinational, zero latency.
// No handshake; the controller samples the result in DECODE.
module rv_decode
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Map opcode/funct fields to operand selects, ALU op and memory op.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    ctrl.cls    = CL_ALU;
    illegal     = 1'b0;
    case (opc)
      OPC_OP: begin
        ctrl.a_sel = ASEL_RS1;
        if (f7 == 7'b0000000)
          ctrl.alu_op = alu_f3(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          ctrl.alu_op = alu_f3(f3, 1'b1);
        else
          illegal = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl.a_sel = ASEL_RS1;
        ctrl.b_sel = 1'b1;
        // funct7 only qualifies the shift-immediate forms
        if (f3 == 3'b001) begin
          ctrl.alu_op = ALU_SLL;
          illegal     = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          ctrl.alu_op = alu_f3(f3, f7[5]);
          illegal     = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end else begin
          ctrl.alu_op = alu_f3(f3, 1'b0);
        end
      end
      OPC_LOAD: begin
        ctrl.cls   = CL_LOAD;
        ctrl.a_sel = ASEL_RS1;
        ctrl.b_sel = 1'b1;
        case (f3)
          3'b000:  ctrl.ls_op = LS_LB;
          3'b001:  ctrl.ls_op = LS_LH;
          3'b010:  ctrl.ls_op = LS_LW;
          3'b100:  ctrl.ls_op = LS_LBU;
          3'b101:  ctrl.ls_op = LS_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.cls     = CL_STORE;
        ctrl.a_sel   = ASEL_RS1;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_S;
        case (f3)
          3'b000:  ctrl.ls_op = LS_SB;
          3'b001:  ctrl.ls_op = LS_SH;
          3'b010:  ctrl.ls_op = LS_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        ctrl.cls     = CL_BRANCH;
        ctrl.a_sel   = ASEL_PC;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_B;
        illegal      = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        ctrl.cls     = CL_JUMP;
        ctrl.a_sel   = ASEL_PC;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_J;
      end
      OPC_JALR: begin
        ctrl.cls   = CL_JUMP;
        ctrl.a_sel = ASEL_RS1;
        ctrl.b_sel = 1'b1;
      end
      OPC_LUI: begin
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.a_sel   = ASEL_PC;
        ctrl.b_sel   = 1'b1;
        ctrl.imm_sel = IMM_U;
      end
      OPC_FENCE: ctrl.cls = CL_FENCE;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I controller: FETCH/DECODE/EXEC/MEM/WB sequencing with trap.
// ALU op 4 cycles, branch 3, store 4, load 5 with zero-wait handshakes.
// Holds imem/dmem requests and waits for alu_valid; optional wait-cycle timeout traps.
module rv_mc_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ALUOP_W     = 5,
  parameter int MEM_TIMEOUT = 0
) (
  input logic          clk,
  input logic          rst,
  rv_mc_ctrl_if.master bus
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("rv_mc_ctrl: XLEN must be 32");
  end
  if (ALUOP_W < 5) begin : g_bad_aluop_w
    $error("rv_mc_ctrl: ALUOP_W must be at least 5");
  end

  localparam logic [15:0] TMO_LAST = 16'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        alu_start_q, alu_start_d;
  logic        trap_q, trap_d;
  trap_cause_e cause_q, cause_d;
  logic [15:0] tmo_q, tmo_d;
  ctrl_t       dec_ctrl;
  logic        dec_illegal;
  logic        tmo_hit;

  rv_decode u_decode (
    .instr   (bus.instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // The last allowed wait cycle; a ready arriving in it still wins.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);

  // Next state, latched control word, trap status and wait counter.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    alu_start_d = 1'b0;
    cause_d     = cause_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) state_d = S_DECODE;
        else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = TC_FETCH_TO;
        end
      end
      S_DECODE: begin
        ctrl_d = dec_ctrl;
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d     = S_EXEC;
          alu_start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (bus.alu_valid) begin
          case (ctrl_q.cls)
            CL_LOAD, CL_STORE:  state_d = S_MEM;
            CL_BRANCH, CL_FENCE: state_d = S_FETCH;
            default:            state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (bus.dmem_ready) state_d = (ctrl_q.cls == CL_LOAD) ? S_WB : S_FETCH;
        else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = TC_DATA_TO;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    trap_d = (state_d == S_TRAP);
    // Counter restarts on every state entry and only runs while waiting on memory.
    if (state_d != state_q || !(state_q inside {S_FETCH, S_MEM})) tmo_d = '0;
    else if (tmo_q != '1) tmo_d = tmo_q + 16'd1;
    else tmo_d = tmo_q;
    if (rst) begin
      state_d     = S_FETCH;
      ctrl_d      = '0;
      alu_start_d = 1'b0;
      trap_d      = 1'b0;
      cause_d     = TC_NONE;
      tmo_d       = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    ctrl_q      <= ctrl_d;
    alu_start_q <= alu_start_d;
    trap_q      <= trap_d;
    cause_q     <= cause_d;
    tmo_q       <= tmo_d;
  end

  assign bus.alu_start  = alu_start_q;
  assign bus.alu_op     = ALUOP_W'(ctrl_q.alu_op);
  assign bus.a_sel      = ctrl_q.a_sel;
  assign bus.b_sel      = ctrl_q.b_sel;
  assign bus.imm_sel    = ctrl_q.imm_sel;
  assign bus.ls_op      = ctrl_q.ls_op;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;

  // Handshake and write pulses; all forced quiet while rst is high.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.wb_sel   = WB_ALU;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_we    = bus.imem_ready;
        end
        S_EXEC: begin
          if (bus.alu_valid && ctrl_q.cls == CL_BRANCH) begin
            bus.pc_we  = 1'b1;
            bus.pc_sel = bus.br_taken;
          end else if (bus.alu_valid && ctrl_q.cls == CL_FENCE) begin
            bus.pc_we = 1'b1;
          end
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = (ctrl_q.cls == CL_STORE);
          bus.pc_we    = bus.dmem_ready && (ctrl_q.cls == CL_STORE);
        end
        S_WB: begin
          bus.rf_we = 1'b1;
          bus.pc_we = 1'b1;
          if (ctrl_q.cls == CL_JUMP) begin
            bus.wb_sel = WB_PC4;
            bus.pc_sel = 1'b1;
          end else if (ctrl_q.cls == CL_LOAD) begin
            bus.wb_sel = WB_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Randomized self-checking bench for rv_mc_ctrl against a transaction-level model.
// Two instances: no timeout (main traffic) and MEM_TIMEOUT=4 (timeout boundaries).
// Datapath responders insert random wait states on every handshake.
module tb_rv_mc_ctrl;

  localparam logic [2:0] K_ALU = 3'd0, K_JMP = 3'd1, K_LD = 3'd2, K_ST = 3'd3, K_BR = 3'd4, K_FEN = 3'd5;

  typedef struct packed {
    logic       legal;
    logic [2:0] kind;
    logic [4:0] aop;
    logic [1:0] asel;
    logic       bsel;
    logic [2:0] imm;
    logic [2:0] ls;
  } exp_t;

  logic clk, rst, rst2;
  int   n_chk = 0;
  int   n_err = 0;

  rv_mc_ctrl_if #(.ALUOP_W(5)) bus ();
  rv_mc_ctrl_if #(.ALUOP_W(5)) bus2 ();

  rv_mc_ctrl #(.XLEN(32), .ALUOP_W(5), .MEM_TIMEOUT(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  rv_mc_ctrl #(.XLEN(32), .ALUOP_W(5), .MEM_TIMEOUT(4)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected behaviour straight from the RV32I decode tables.
  function automatic exp_t ref_model(input logic [31:0] ins);
    exp_t e;
    logic [4:0] base [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    base = '{5'b00001, 5'b01110, 5'b10001, 5'b10010, 5'b01101, 5'b01111, 5'b01100, 5'b01010};
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    e = '0;
    e.legal = 1'b1;
    e.aop = 5'b00001;
    e.bsel = 1'b1;
    case (opc)
      7'h33: begin
        e.kind = K_ALU; e.asel = 2'b01; e.bsel = 1'b0;
        if (f7 == 7'h00) e.aop = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.aop = 5'b00011;
        else if (f7 == 7'h20 && f3 == 3'd5) e.aop = 5'b10000;
        else e.legal = 1'b0;
      end
      7'h13: begin
        e.kind = K_ALU; e.asel = 2'b01;
        e.aop = base[f3];
        if (f3 == 3'd1 && f7 != 7'h00) e.legal = 1'b0;
        if (f3 == 3'd5 && f7 == 7'h20) e.aop = 5'b10000;
        else if (f3 == 3'd5 && f7 != 7'h00) e.legal = 1'b0;
      end
      7'h03: begin
        e.kind = K_LD; e.asel = 2'b01;
        case (f3)
          3'd0: e.ls = 3'b100;
          3'd1: e.ls = 3'b101;
          3'd2: e.ls = 3'b000;
          3'd4: e.ls = 3'b110;
          3'd5: e.ls = 3'b111;
          default: e.legal = 1'b0;
        endcase
      end
      7'h23: begin
        e.kind = K_ST; e.asel = 2'b01; e.imm = 3'b001;
        if (f3 > 3'd2) e.legal = 1'b0;
        else e.ls = f3 + 3'd1;
      end
      7'h63: begin
        e.kind = K_BR; e.asel = 2'b10; e.imm = 3'b010;
        if (f3 == 3'd2 || f3 == 3'd3) e.legal = 1'b0;
      end
      7'h6F: begin e.kind = K_JMP; e.asel = 2'b10; e.imm = 3'b100; end
      7'h67: begin e.kind = K_JMP; e.asel = 2'b01; end
      7'h37: begin e.kind = K_ALU; e.asel = 2'b00; e.imm = 3'b011; end
      7'h17: begin e.kind = K_ALU; e.asel = 2'b10; e.imm = 3'b011; end
      7'h0F: e.kind = K_FEN;
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [12];
    logic [6:0] opc, f7;
    int r;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h33};
    opc = opcs[$urandom_range(11)];
    if ($urandom_range(11) == 0) opc = 7'($urandom);
    r = $urandom_range(9);
    f7 = (r < 5) ? 7'h00 : (r < 8) ? 7'h20 : 7'($urandom);
    return {f7, 10'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  task automatic reset_and_check();
    bus.imem_ready = 1'b0; bus.alu_valid = 1'b0; bus.dmem_ready = 1'b0; bus.br_taken = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
    chk("rst_trap", 32'({bus.trap, bus.trap_cause}), 32'd0);
    chk("rst_pulses", 32'({bus.ir_we, bus.alu_start, bus.dmem_req, bus.rf_we, bus.pc_we}), 32'd0);
    chk("rst_fields", 32'({bus.alu_op, bus.a_sel, bus.b_sel, bus.imm_sel, bus.ls_op, bus.wb_sel}), 32'd0);
  endtask

  // Run one instruction from FETCH with given wait states; called at posedge+1.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int aw, input int mw, input logic tk);
    exp_t e;
    int cyc, fcnt, acnt, mcnt, n_ir, n_rf, n_pc, n_dreq, n_as, rf_cyc, pc_cyc, trap_cyc, exp_pc;
    bit ex, done, mem, wb;
    logic [1:0] wbs, asel;
    logic pcs, dwe, bsel;
    logic [2:0] lso, isel;
    logic [4:0] aop;
    e = ref_model(ins);
    cyc = 0; fcnt = 0; acnt = 0; mcnt = 0; n_ir = 0; n_rf = 0; n_pc = 0; n_dreq = 0; n_as = 0;
    rf_cyc = -1; pc_cyc = -1; trap_cyc = -1; ex = 0; done = 0;
    wbs = '0; asel = '0; pcs = 0; dwe = 0; bsel = 0; lso = '0; isel = '0; aop = '0;
    bus.instr = ins;
    bus.br_taken = tk;
    while (!done && cyc < 100) begin
      if (bus.alu_start) begin ex = 1; acnt = 0; end
      bus.imem_ready = bus.imem_req && (fcnt == fw);
      bus.alu_valid  = ex && (acnt == aw);
      bus.dmem_ready = bus.dmem_req && (mcnt == mw);
      @(negedge clk);
      cyc++;
      if (bus.imem_req) fcnt++;
      if (bus.ir_we) n_ir++;
      if (bus.alu_start) begin
        n_as++; aop = bus.alu_op; asel = bus.a_sel; bsel = bus.b_sel; isel = bus.imm_sel;
      end
      if (ex) begin
        if (bus.alu_valid) ex = 0;
        else acnt++;
      end
      if (bus.dmem_req) begin n_dreq++; mcnt++; dwe = bus.dmem_we; lso = bus.ls_op; end
      if (bus.rf_we) begin n_rf++; rf_cyc = cyc; wbs = bus.wb_sel; end
      if (bus.pc_we) begin n_pc++; pc_cyc = cyc; pcs = bus.pc_sel; done = 1; end
      if (bus.trap) begin trap_cyc = cyc; done = 1; end
      @(posedge clk); #1;
    end
    chk("finished", 32'(done), 32'd1);
    if (!e.legal) begin
      chk("trap_cycle", 32'(trap_cyc), 32'(fw + 3));
      chk("trap_cause", 32'(bus.trap_cause), 32'd1);
      chk("trap_no_exec", 32'(n_as + n_pc + n_rf), 32'd0);
      for (int i = 0; i < 3; i++) begin
        bus.imem_ready = 1'b1; bus.alu_valid = 1'b1; bus.dmem_ready = 1'b1;
        @(negedge clk);
        chk("trap_quiet", 32'({bus.imem_req, bus.ir_we, bus.alu_start, bus.dmem_req,
                               bus.rf_we, bus.pc_we, bus.trap}), 32'd1);
        @(posedge clk); #1;
      end
      reset_and_check();
    end else begin
      mem = (e.kind == K_LD) || (e.kind == K_ST);
      wb  = (e.kind == K_ALU) || (e.kind == K_JMP) || (e.kind == K_LD);
      exp_pc = (fw + 1) + 1 + (aw + 1) + (mem ? mw + 1 : 0) + (wb ? 1 : 0);
      chk("pc_we_cycle", 32'(pc_cyc), 32'(exp_pc));
      chk("pulse_counts", 32'({8'(n_ir), 8'(n_as), 8'(n_pc), 8'(n_rf)}),
          32'({8'd1, 8'd1, 8'd1, 8'(wb ? 1 : 0)}));
      chk("dmem_req_cycles", 32'(n_dreq), 32'(mem ? mw + 1 : 0));
      chk("pc_sel", 32'(pcs), 32'((e.kind == K_BR) ? tk : (e.kind == K_JMP)));
      if (wb) begin
        chk("rf_we_cycle", 32'(rf_cyc), 32'(pc_cyc));
        chk("wb_sel", 32'(wbs), (e.kind == K_JMP) ? 32'd2 : (e.kind == K_LD) ? 32'd1 : 32'd0);
      end
      if (mem) chk("dmem_op", 32'({dwe, lso}), 32'({(e.kind == K_ST), e.ls}));
      if (e.kind != K_FEN)
        chk("decode_fields", 32'({aop, asel, bsel, isel}), 32'({e.aop, e.asel, e.bsel, e.imm}));
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.instr = '0; bus.imem_ready = 0; bus.alu_valid = 0; bus.br_taken = 0; bus.dmem_ready = 0;
    bus2.instr = '0; bus2.imem_ready = 0; bus2.alu_valid = 0; bus2.br_taken = 0; bus2.dmem_ready = 0;
    @(posedge clk); #1;
    reset_and_check();

    // Directed: ADD, BEQ taken/not taken, LHU with 3 data waits, SW, ECALL.
    run_instr(32'h002081B3, 0, 0, 0, 1'b0);
    run_instr(32'h00208063, 0, 0, 0, 1'b1);
    run_instr(32'h00208063, 0, 0, 0, 1'b0);
    run_instr(32'h0000D083, 0, 0, 3, 1'b0);
    run_instr(32'h0020A023, 0, 0, 0, 1'b0);
    run_instr(32'h00000073, 1, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++)
      run_instr(rand_instr(), $urandom_range(3), $urandom_range(3), $urandom_range(3), 1'($urandom));

    // Reset while a store sits in MEM.
    reset_and_check();
    bus.instr = 32'h0020A023; bus.imem_ready = 1; bus.alu_valid = 1; bus.dmem_ready = 0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("sw_in_mem", 32'({bus.dmem_req, bus.dmem_we}), 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_in_mem_quiet", 32'({bus.dmem_req, bus.pc_we, bus.rf_we, bus.ir_we}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.imem_ready = 0; bus.alu_valid = 0;
    #1;
    chk("rst_in_mem_fetch", 32'({bus.imem_req, bus.dmem_req, bus.pc_we}), 32'd4);

    // Timeout instance: fetch never answered.
    @(posedge clk); #1;
    rst2 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("fetch_limit_cycle", 32'({bus2.trap, bus2.imem_req}), 32'd1);
    @(posedge clk); #1;
    chk("fetch_timeout", 32'({bus2.trap, bus2.trap_cause, bus2.imem_req}), 32'b1100);

    // Ready in the limit cycle wins; then a load stalls in MEM until data timeout.
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    bus2.instr = 32'h0000A083; bus2.alu_valid = 1; bus2.dmem_ready = 0;
    repeat (3) begin @(posedge clk); #1; end
    bus2.imem_ready = 1;
    @(negedge clk);
    chk("fetch_ready_at_limit", 32'({bus2.ir_we, bus2.trap}), 32'd2);
    @(posedge clk); #1;
    bus2.imem_ready = 0;
    chk("decode_after_limit", 32'({bus2.trap, bus2.imem_req}), 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("mem_limit_cycle", 32'({bus2.dmem_req, bus2.trap}), 32'd2);
    @(posedge clk); #1;
    chk("data_timeout", 32'({bus2.trap, bus2.trap_cause, bus2.dmem_req}), 32'b1110);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
